fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: FETCH waits on imem_ready, HOLD waits on retire.
// Computes the next PC (sequential, branch, jump) and counts retired instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] retired_count
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc_plus4      = pc_q + 32'd4;
  assign imem_addr     = pc_q;
  assign imem_req      = (state_q == S_FETCH);
  assign instr         = instr_q;
  assign op_code       = instr_q[31:26];
  assign instr_valid   = vld_q;
  assign retired_count = cnt_q;

  // Word offset of the branch, sign-extended and scaled to bytes.
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      default: begin
        // Control inputs only matter on the retire edge.
        if (retire) begin
          pc_d    = next_pc;
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      vld_q   <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses,
// instruction captures and retire counts; a negedge monitor pops and compares.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] retired_count;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .op_code(op_code), .instr_valid(instr_valid),
    .pc_plus4(pc_plus4), .retire(retire),
    .branch(branch), .zero(zero), .jump(jump),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [5:0]  op;
    logic [31:0] pp4;
  } cap_t;

  logic [31:0] addr_q[$];
  cap_t        cap_q[$];
  logic [31:0] cnt_q[$];

  int checks = 0;
  int errors = 0;
  logic        mon_en = 1'b0;
  logic        prev_vld;
  logic [31:0] prev_cnt;
  logic [31:0] model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic underflow(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry (got count %h)", name, retired_count);
  endtask

  // Monitor: pops whenever the DUT presents a handshake, capture, or count change.
  always @(negedge clk) begin
    if (mon_en) begin
      check("req_vs_valid", {31'd0, imem_req}, {31'd0, ~instr_valid});
      if (imem_req && imem_ready) begin
        if (addr_q.size() == 0) underflow("fetch_addr");
        else check("fetch_addr", imem_addr, addr_q.pop_front());
      end
      if (instr_valid && !prev_vld) begin
        if (cap_q.size() == 0) underflow("capture");
        else begin
          cap_t c;
          c = cap_q.pop_front();
          check("instr", instr, c.ins);
          check("op_code", {26'd0, op_code}, {26'd0, c.op});
          check("pc_plus4", pc_plus4, c.pp4);
        end
      end
      if (retired_count !== prev_cnt) begin
        if (cnt_q.size() == 0) underflow("retired_count");
        else check("retired_count", retired_count, cnt_q.pop_front());
      end
      prev_vld = instr_valid;
      prev_cnt = retired_count;
    end
  end

  // Caller is positioned 1 time unit after a rising edge; DUT is expected in FETCH.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    cap_t c;
    branch = 1'b1; zero = 1'b1; jump = 1'b1;
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      retire     = (i % 2 == 0);
      @(negedge clk);
      check("wait_addr", imem_addr, addr);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    retire     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    addr_q.push_back(addr);
    c.ins = data; c.op = data[31:26]; c.pp4 = addr + 32'd4;
    cap_q.push_back(c);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hA5A5_5A5A;
  endtask

  task automatic do_retire(input logic br, input logic z, input logic j);
    retire = 1'b1; branch = br; zero = z; jump = j;
    model_cnt = model_cnt + 32'd1;
    cnt_q.push_back(model_cnt);
    @(posedge clk); #1;
    retire = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
  endtask

  // Present a stale memory response in HOLD; it must not disturb the held instruction.
  task automatic hold_noise(input logic [31:0] held);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(negedge clk);
    check("hold_instr", instr, held);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    retire = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    model_cnt = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_op", {26'd0, op_code}, 32'd0);
    check("rst_pp4", pc_plus4, 32'h4);
    prev_vld = instr_valid;
    prev_cnt = retired_count;
    mon_en   = 1'b1;
    @(posedge clk); #1;

    // Sequential fetch/retire, with a stale response ignored in HOLD.
    fetch(32'h0, 32'h2008_0005, 0);
    hold_noise(32'h2008_0005);
    do_retire(1'b0, 1'b0, 1'b0);
    // Wait states with retire pulses that must be ignored.
    fetch(32'h4, 32'h2009_0001, 3);
    do_retire(1'b0, 1'b0, 1'b0);
    fetch(32'h8, 32'h0000_0000, 1);
    do_retire(1'b0, 1'b0, 1'b0);
    fetch(32'hC, 32'h0000_0000, 0);
    do_retire(1'b0, 1'b0, 1'b0);
    // Branch back to itself, then not taken.
    fetch(32'h10, 32'h1000_FFFF, 0);
    do_retire(1'b1, 1'b1, 1'b0);
    fetch(32'h10, 32'h1000_FFFF, 0);
    do_retire(1'b1, 1'b0, 1'b0);
    // Forward branch: 0x18 + 8.
    fetch(32'h14, 32'h1000_0002, 0);
    do_retire(1'b1, 1'b1, 1'b0);
    // jal with branch also asserted: jump wins.
    fetch(32'h20, 32'h0C00_0040, 0);
    do_retire(1'b1, 1'b1, 1'b1);
    fetch(32'h100, 32'h2008_0007, 2);

    // Reset in HOLD together with retire.
    rst_n = 1'b0; retire = 1'b1;
    model_cnt = 32'd0;
    cnt_q.push_back(32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; retire = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd1);
    check("mid_rst_instr", instr, 32'h0);
    @(posedge clk); #1;

    // Branch from 0 back by two words lands at 0xFFFF_FFFC; sequential step wraps to 0.
    fetch(32'h0, 32'h1000_FFFE, 0);
    do_retire(1'b1, 1'b1, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    do_retire(1'b0, 1'b0, 1'b0);
    fetch(32'h0, 32'h2008_0005, 0);
    do_retire(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("addr_q_left", addr_q.size(), 32'd0);
    check("cap_q_left", cap_q.size(), 32'd0);
    check("cnt_q_left", cnt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
